// File: rtl/game_pkg.sv
// Shared encodings for the game controller and its referee.
//  - Controller STATE codes (4-bit), also consumed by CONTROL.
//  - JUDG / WRONG / HP_OUT output codes driven by hp_judge.
//  - Judge FSM state type and a helper that flags recognised STATE codes.
package game_pkg;

  localparam logic [3:0] ST_READY    = 4'd2;
  localparam logic [3:0] ST_QUESTION = 4'd3;
  localparam logic [3:0] ST_INPUT    = 4'd4;
  localparam logic [3:0] ST_DRAW     = 4'd6;
  localparam logic [3:0] ST_WRONG    = 4'd7;
  localparam logic [3:0] ST_GOOD     = 4'd8;
  localparam logic [3:0] ST_OUCH     = 4'd9;
  localparam logic [3:0] ST_WIN      = 4'd10;
  localparam logic [3:0] ST_LOSE     = 4'd11;

  localparam logic [1:0] JUDG_NONE = 2'b00;
  localparam logic [1:0] JUDG_P1   = 2'b01;
  localparam logic [1:0] JUDG_P2   = 2'b10;
  localparam logic [1:0] JUDG_BOTH = 2'b11;

  localparam logic [1:0] WR_NONE = 2'b00;
  localparam logic [1:0] WR_OK   = 2'b01;
  localparam logic [1:0] WR_BAD  = 2'b11;

  localparam logic [1:0] HP_ALIVE  = 2'b00;
  localparam logic [1:0] HP_P2DEAD = 2'b01;
  localparam logic [1:0] HP_P1DEAD = 2'b10;

  typedef enum logic [1:0] {
    J_IDLE  = 2'd0,
    J_OPEN  = 2'd1,
    J_WRONG = 2'd2,
    J_LOCK  = 2'd3
  } judge_state_e;

  // Codes outside this set freeze the judge (no transitions, no damage).
  function automatic logic state_known(input logic [3:0] s);
    case (s)
      ST_READY, ST_QUESTION, ST_INPUT, ST_DRAW, ST_WRONG,
      ST_GOOD, ST_OUCH, ST_WIN, ST_LOSE: state_known = 1'b1;
      default:                           state_known = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/hp_judge_counter.sv
// Saturating hit-point down-counter, one instance per player.
//  clk, rst : clock, synchronous active-high reset (reloads HP_INIT)
//  load     : reload HP_INIT (new game); wins over hit
//  hit      : subtract DMG, clamping at 0
//  hp       : registered hit points
//  zero     : hit points will be 0 after this edge (post-update view, so
//             the parent can register a status flag aligned with hp)
module hp_counter #(
  parameter int unsigned HP_INIT = 5,
  parameter int unsigned DMG     = 1,
  parameter int unsigned HP_W    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            hit,
  output logic [HP_W-1:0] hp,
  output logic            zero
);

  localparam logic [HP_W-1:0] INIT_V = HP_W'(HP_INIT);
  localparam logic [HP_W-1:0] DMG_V  = HP_W'(DMG);

  logic [HP_W-1:0] hp_q, hp_d;

  always_comb begin
    hp_d = hp_q;
    if (load)     hp_d = INIT_V;
    else if (hit) hp_d = (hp_q < DMG_V) ? '0 : hp_q - DMG_V;
  end

  always_ff @(posedge clk) begin
    if (rst) hp_q <= INIT_V;
    else     hp_q <= hp_d;
  end

  assign hp   = hp_q;
  assign zero = (rst ? INIT_V : hp_d) == '0;

endmodule

// File: rtl/hp_judge.sv
// Referee for the game controller: decides who answered first, whether the
// local answer was right, tracks both players' hit points and reports
// knockouts. All outputs are registered.
//  CLK, RST      : clock, synchronous active-high reset
//  STATE         : controller state code (game_pkg ST_*)
//  P1_VALID/OK   : local answer pulse and its correctness
//  P2_VALID      : opponent correct-answer pulse
//  JUDG_OUT      : who answered first (JUDG_*)
//  WRONG_OUT     : local answer verdict (WR_*)
//  HP_OUT        : knockout status (HP_*)
//  HP1, HP2      : local / opponent hit points
module hp_judge
  import game_pkg::*;
#(
  parameter int unsigned HP_INIT = 5,
  parameter int unsigned DMG     = 1,
  parameter int unsigned HP_W    = 4
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [3:0]      STATE,
  input  logic            P1_VALID,
  input  logic            P1_OK,
  input  logic            P2_VALID,
  output logic [1:0]      JUDG_OUT,
  output logic [1:0]      WRONG_OUT,
  output logic [1:0]      HP_OUT,
  output logic [HP_W-1:0] HP1,
  output logic [HP_W-1:0] HP2
);

  judge_state_e fsm_q, fsm_d;
  logic [1:0]   judg_q, judg_d;
  logic [1:0]   wrong_q, wrong_d;
  logic [1:0]   hp_out_q, hp_out_d;
  logic [3:0]   prev_state_q, prev_state_d;

  logic known, p1_in, p1_good, p1_bad;
  logic hit1, hit2, new_game;
  logic zero1, zero2;

  assign known = state_known(STATE);
  // Local submissions only count while the controller is in INPUT.
  assign p1_in   = P1_VALID && (STATE == ST_INPUT);
  assign p1_good = p1_in && P1_OK;
  assign p1_bad  = p1_in && !P1_OK;

  always_comb begin
    fsm_d   = fsm_q;
    judg_d  = judg_q;
    wrong_d = wrong_q;
    if (STATE == ST_READY) begin
      fsm_d   = J_IDLE;
      judg_d  = JUDG_NONE;
      wrong_d = WR_NONE;
    end else if (known) begin
      case (fsm_q)
        J_IDLE: begin
          judg_d  = JUDG_NONE;
          wrong_d = WR_NONE;
          if (STATE == ST_QUESTION || STATE == ST_INPUT) fsm_d = J_OPEN;
        end
        J_OPEN: begin
          if (p1_good && P2_VALID) begin
            judg_d = JUDG_BOTH; wrong_d = WR_OK;   fsm_d = J_LOCK;
          end else if (p1_good) begin
            judg_d = JUDG_P1;   wrong_d = WR_OK;   fsm_d = J_LOCK;
          end else if (P2_VALID) begin
            judg_d = JUDG_P2;   wrong_d = WR_NONE; fsm_d = J_LOCK;
          end else if (p1_bad) begin
            wrong_d = WR_BAD;   fsm_d = J_WRONG;
          end
        end
        J_WRONG: begin
          // Opponent steals the round; WRONG stays BAD so CONTROL goes to OUCH.
          if (P2_VALID) begin
            judg_d = JUDG_P2; fsm_d = J_LOCK;
          end else if (STATE == ST_INPUT && prev_state_q == ST_WRONG) begin
            wrong_d = WR_NONE; fsm_d = J_OPEN;
          end
        end
        default: ;  // J_LOCK: hold verdict until READY
      endcase
    end
  end

  // Damage fires once on entry to GOOD/OUCH, not for every cycle spent there.
  assign hit2     = (STATE == ST_GOOD) && (prev_state_q != ST_GOOD);
  assign hit1     = (STATE == ST_OUCH) && (prev_state_q != ST_OUCH);
  assign new_game = (STATE == ST_READY) &&
                    (prev_state_q == ST_WIN || prev_state_q == ST_LOSE);

  hp_counter #(.HP_INIT(HP_INIT), .DMG(DMG), .HP_W(HP_W)) u_hp1 (
    .clk (CLK), .rst (RST), .load (new_game), .hit (hit1),
    .hp  (HP1), .zero (zero1)
  );

  hp_counter #(.HP_INIT(HP_INIT), .DMG(DMG), .HP_W(HP_W)) u_hp2 (
    .clk (CLK), .rst (RST), .load (new_game), .hit (hit2),
    .hp  (HP2), .zero (zero2)
  );

  always_comb begin
    prev_state_d = STATE;
    if (zero1)      hp_out_d = HP_P1DEAD;
    else if (zero2) hp_out_d = HP_P2DEAD;
    else            hp_out_d = HP_ALIVE;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      fsm_q        <= J_IDLE;
      judg_q       <= JUDG_NONE;
      wrong_q      <= WR_NONE;
      hp_out_q     <= HP_ALIVE;
      prev_state_q <= ST_READY;
    end else begin
      fsm_q        <= fsm_d;
      judg_q       <= judg_d;
      wrong_q      <= wrong_d;
      hp_out_q     <= hp_out_d;
      prev_state_q <= prev_state_d;
    end
  end

  assign JUDG_OUT  = judg_q;
  assign WRONG_OUT = wrong_q;
  assign HP_OUT    = hp_out_q;

endmodule
